// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: walks fetch_pc through a combinational instruction memory,
// buffers {pc, instr} pairs in a small prefetch FIFO and hands them to decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MEM_BYTES  = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [32:0] MemLimit = 33'(MEM_BYTES);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     pc_q    [FIFO_DEPTH];
  logic [31:0]     instr_q [FIFO_DEPTH];

  logic        fifo_empty;
  logic        pop;
  logic        space;
  logic        fetch_req;
  logic        out_of_range;
  logic        push;
  logic [31:0] redirect_target;

  assign fifo_empty      = (count_q == '0);
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    // A pop coinciding with a redirect is dropped along with the rest of the FIFO.
    pop          = !fifo_empty && out_ready && !redirect_valid;
    space        = (count_q < DepthCnt) || pop;
    fetch_req    = fetch_en && !redirect_valid && (state_q == StRun) && space;
    out_of_range = ({1'b0, fetch_pc_q} >= MemLimit);
    push         = fetch_req && !out_of_range;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      state_d    = StRun;
      fetch_pc_d = redirect_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (fetch_req && out_of_range) begin
        state_d = StFault;
      end
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset: outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]    <= fetch_pc_q;
      instr_q[wr_ptr_q] <= imem_instr;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign out_valid   = !fifo_empty;
  assign out_pc      = fifo_empty ? 32'h0 : pc_q[rd_ptr_q];
  assign out_instr   = fifo_empty ? 32'h0 : instr_q[rd_ptr_q];
  assign fetch_fault = (state_q == StFault);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_unit;

  localparam logic [31:0] ResetPc  = 32'h0000_0000;
  localparam int unsigned Depth    = 2;
  localparam int unsigned MemBytes = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // Model state: the queue of pending {pc, instr}, the next fetch address, the fault flag.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_instr[$];
  logic [31:0] m_pc;
  bit          m_fault;
  bit          m_pop;
  bit          m_go;

  always #5 clk = ~clk;

  // Memory contents: word i holds "addi xi, x0, i" (0x00000013, 0x00100093, ...).
  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] i;
    i = a >> 2;
    return (i << 20) | ((i & 32'd31) << 7) | 32'h13;
  endfunction

  assign imem_instr = word(imem_addr);

  instr_fetch_unit #(
    .RESET_PC  (ResetPc),
    .FIFO_DEPTH(Depth),
    .MEM_BYTES (MemBytes)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_fault   (fetch_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: advances once per rising edge, or clears on reset assertion.
  initial begin
    mq_pc.delete();
    mq_instr.delete();
    m_pc    = ResetPc;
    m_fault = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq_pc.delete();
        mq_instr.delete();
        m_pc    = ResetPc;
        m_fault = 1'b0;
      end else if (redirect_valid) begin
        mq_pc.delete();
        mq_instr.delete();
        m_pc    = redirect_pc & 32'hFFFF_FFFC;
        m_fault = 1'b0;
      end else begin
        m_pop = (mq_pc.size() > 0) && out_ready;
        m_go  = fetch_en && !m_fault && ((mq_pc.size() < Depth) || m_pop);
        if (m_pop) begin
          void'(mq_pc.pop_front());
          void'(mq_instr.pop_front());
        end
        if (m_go) begin
          if (m_pc >= MemBytes) begin
            m_fault = 1'b1;
          end else begin
            mq_pc.push_back(m_pc);
            mq_instr.push_back(word(m_pc));
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("m_valid", {31'b0, out_valid}, {31'b0, (mq_pc.size() > 0)});
        chk("m_pc", out_pc, (mq_pc.size() > 0) ? mq_pc[0] : 32'h0);
        chk("m_instr", out_instr, (mq_instr.size() > 0) ? mq_instr[0] : 32'h0);
        chk("m_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        chk("m_addr", imem_addr, m_pc);
      end
    end
  end

  task automatic sync_reset(input bit en, input bit rdy);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    fetch_en  = en;
    out_ready = rdy;
    rst_n     = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(negedge clk);
    started = 1'b1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    // Stream from reset.
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("s0_valid", {31'b0, out_valid}, 32'h1);
    chk("s0_pc", out_pc, 32'h0);
    chk("s0_instr", out_instr, 32'h0000_0013);
    @(negedge clk);
    chk("s1_pc", out_pc, 32'h4);
    chk("s1_instr", out_instr, 32'h0010_0093);
    @(negedge clk);
    chk("s2_pc", out_pc, 32'h8);
    chk("s2_instr", out_instr, 32'h0020_0113);

    // Backpressure from reset: FIFO fills with 0 and 4, fetch stalls at 8.
    sync_reset(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel0", out_pc, 32'h4);
    @(negedge clk);
    chk("bp_rel1", out_pc, 32'h8);

    // Redirect with two entries queued: stale entries vanish.
    redirect(32'h0000_0022);
    chk("rd_valid", {31'b0, out_valid}, 32'h0);
    chk("rd_addr", imem_addr, 32'h20);
    @(negedge clk);
    chk("rd_pc", out_pc, 32'h20);
    chk("rd_instr", out_instr, 32'h0080_0413);

    // End of memory, then recovery by redirect.
    redirect(32'h0000_0078);
    @(negedge clk);
    chk("eom_pc0", out_pc, 32'h78);
    @(negedge clk);
    chk("eom_pc1", out_pc, 32'h7C);
    chk("eom_nofault", {31'b0, fetch_fault}, 32'h0);
    @(negedge clk);
    chk("eom_fault", {31'b0, fetch_fault}, 32'h1);
    chk("eom_valid", {31'b0, out_valid}, 32'h0);
    redirect(32'h0000_0004);
    chk("eom_clear", {31'b0, fetch_fault}, 32'h0);
    @(negedge clk);
    chk("eom_resume", out_pc, 32'h4);

    // fetch_en low with a full FIFO: drain, PC frozen, resume without gap.
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    fetch_en  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("fe_valid", {31'b0, out_valid}, 32'h0);
    chk("fe_addr", imem_addr, 32'hC);
    fetch_en = 1'b1;
    @(negedge clk);
    chk("fe_resume", out_pc, 32'hC);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      fetch_en  = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 160));
      end else begin
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;

    // Asynchronous reset between edges with entries queued.
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    redirect(32'h0000_0010);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'h0);
    chk("ar_fault", {31'b0, fetch_fault}, 32'h0);
    chk("ar_addr", imem_addr, ResetPc);
    @(negedge clk);
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("ar_restart", out_pc, ResetPc);
    @(negedge clk);
    chk("ar_next", out_pc, ResetPc + 32'd4);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Initiator side of the instruction-memory interface. Drives word addresses into the instruction memory, captures the returned 32-bit instructions into a small prefetch FIFO, and presents them with their PC to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage, and supports redirects (branch/jump) with a full flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2: prefetch entries; power of two, at least 2.
- MEM_BYTES, 128: instruction memory size in bytes (4 × memory NUM_INSTR).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits new fetches; the FIFO keeps draining while low.
- imem_addr  out  32  byte address to the instruction memory interface `addr`.
- imem_instr  in  32  instruction from the memory interface `instr`, valid combinationally in the same cycle.
- redirect_valid  in  1  one-cycle pulse that loads a new fetch PC.
- redirect_pc  in  32  target PC; bits [1:0] are forced to 0.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- fetch_fault  out  1  sticky flag: fetch PC has left [0, MEM_BYTES).

## Operation
- Registers:
  - fetch_pc.
  - FIFO of {pc, instr} entries with read pointer, write pointer and count (width clog2(FIFO_DEPTH)+1).
  - state.
- imem_addr = fetch_pc at all times. The memory is combinational, so a fetch completes in the cycle it is issued.
- States:
  - RUN: push {fetch_pc, imem_instr} when all of the following hold: fetch_en=1, no redirect, fault clear, and space is available. Space means count<FIFO_DEPTH, or a pop happens in the same cycle. On push, fetch_pc += 4 (mod 2^32).
  - FAULT: entered instead of pushing when fetch_pc >= MEM_BYTES. Sets fetch_fault=1 and stops pushing. Already-queued entries still drain. Only a redirect or a reset leaves FAULT.
- Pop: out_valid && out_ready.
- Redirect (highest priority):
  - In the cycle redirect_valid=1, clear the FIFO (count=0, pointers=0).
  - fetch_pc <= {redirect_pc[31:2],2'b00}; fetch_fault <= 0; state <= RUN.
  - No push in that cycle. A pop asserted by decode in the same cycle is discarded (no effect).
- Simultaneous push and pop while full: both happen and count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Reset, applied any time including mid-operation:
  - fetch_pc=RESET_PC, FIFO empty, state RUN.
  - out_valid=0, fetch_fault=0, out_instr=0, out_pc=0. These values hold whenever the FIFO is empty.

## Timing
- Fetch-to-output latency is 1 cycle: a push at edge N gives out_valid=1 after edge N, with that entry at the head if the FIFO was empty.
- Throughput is 1 instruction/cycle sustained when out_ready=1 continuously.
- First edge after rst_n rises with fetch_en=1 pushes the RESET_PC instruction. out_valid rises after that edge.
- Redirect at edge R:
  - out_valid=0 after R.
  - The first instruction from redirect_pc is pushed at R+1 and appears after R+1.
  - Redirect penalty is 2 cycles of head latency.
- out_instr, out_pc and out_valid come from registers only; there is no combinational path from imem_instr to the outputs.
- out_ready may combinationally affect the push-enable (space test) but no output port.
- fetch_fault rises on the edge where the out-of-range fetch would have been pushed.

## Test plan
- Reset then stream: RESET_PC=0, memory words 0x00000013, 0x00100093, …, out_ready=1 → out_valid from cycle 1; out_pc sequence 0,4,8,…; instr matches memory word for word.
- Backpressure: out_ready=0 for 5 cycles → count saturates at FIFO_DEPTH, fetch_pc stops at 8 (DEPTH=2), no entry lost or duplicated. Release out_ready → order preserved.
- Redirect: redirect_valid with redirect_pc=0x22 while the FIFO holds 2 entries → out_valid=0 the next cycle, next out_pc=0x20, and no stale PC (e.g. 0x08) ever appears.
- End of memory: MEM_BYTES=16, out_ready=1 → PCs 0,4,8,12 delivered, then fetch_fault=1 and out_valid falls. A redirect to 0x4 clears the fault and resumes at 0x4.
- fetch_en low: deassert for 3 cycles with the FIFO full → FIFO drains, fetch_pc stays frozen, and fetching resumes at the same PC with no gap in the sequence.
- Async reset mid-stream: drop rst_n between edges → out_valid=0 and fetch_fault=0 immediately. After release, the sequence restarts at RESET_PC.
